// File: rtl/xui_mem_model_if.sv
// MIG user-interface (UI) bundle: command, write-data and read-return signals.
// The master drives commands and write data; the slave answers with ready flags and read beats.
interface xui_mem_model_if #(
  parameter int ADDR_SIZE = 31,
  parameter int DATA_SIZE = 64
);
  logic [ADDR_SIZE-1:0]   app_addr;
  logic [2:0]             app_cmd;
  logic                   app_en;
  logic                   app_rdy;
  logic                   app_wdf_wren;
  logic [DATA_SIZE-1:0]   app_wdf_data;
  logic [DATA_SIZE/8-1:0] app_wdf_mask;
  logic                   app_wdf_end;
  logic                   app_wdf_rdy;
  logic [DATA_SIZE-1:0]   app_rd_data;
  logic                   app_rd_data_valid;
  logic                   app_rd_data_end;
  logic                   init_calib_complete;

  modport master (
    output app_addr, app_cmd, app_en, app_wdf_wren, app_wdf_data, app_wdf_mask, app_wdf_end,
    input  app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid, app_rd_data_end,
           init_calib_complete
  );

  modport slave (
    input  app_addr, app_cmd, app_en, app_wdf_wren, app_wdf_data, app_wdf_mask, app_wdf_end,
    output app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid, app_rd_data_end,
           init_calib_complete
  );
endinterface

// File: rtl/xui_mem_model.sv
// Cycle-level MIG UI responder: calibration delay, write-data FIFO, byte-masked writes and
// critical-word-first read bursts against an internal word array, all in the UI clock domain.
module xui_mem_model #(
  parameter int ADDR_SIZE    = 31,
  parameter int DATA_SIZE    = 64,
  parameter int BURST_LEN    = 8,
  parameter int MEM_WORDS_LG = 12,
  parameter int CALIB_CYCLES = 16,
  parameter int RD_LATENCY   = 4,
  parameter int WDF_DEPTH    = 4
) (
  input  logic ui_clk,
  input  logic sys_reset,
  output logic ui_clk_sync_rst,
  xui_mem_model_if.slave ui
);
  localparam int BytesW  = DATA_SIZE / 8;
  localparam int ByteLg  = $clog2(BytesW);
  localparam int BurstLg = $clog2(BURST_LEN);
  localparam int WdfLg   = $clog2(WDF_DEPTH);
  localparam int CalW    = $clog2(CALIB_CYCLES + 1);
  localparam int LatW    = $clog2(RD_LATENCY + 1);
  localparam int Words   = 1 << MEM_WORDS_LG;
  localparam logic [2:0] CmdWrite = 3'b000;
  localparam logic [2:0] CmdRead  = 3'b001;

  typedef enum logic [2:0] {CALIB, IDLE, WDWAIT, RDLAT, RDBURST} state_e;
  typedef logic [MEM_WORDS_LG-1:0] idx_t;

  state_e               state_q, state_d;
  logic [CalW-1:0]      calCnt_q, calCnt_d;
  logic [LatW-1:0]      latCnt_q, latCnt_d;
  logic [BurstLg:0]     beatCnt_q, beatCnt_d;
  idx_t                 rdIdx_q, rdIdx_d;
  idx_t                 wrIdx_q, wrIdx_d;

  logic [DATA_SIZE-1:0] mem [Words];
  logic [DATA_SIZE-1:0] wdfData_q [WDF_DEPTH];
  logic [BytesW-1:0]    wdfMask_q [WDF_DEPTH];
  logic [WdfLg-1:0]     wdfRd_q, wdfWr_q;
  logic [WdfLg:0]       wdfCnt_q;

  logic [DATA_SIZE-1:0] rdData_q;
  logic                 rdValid_q, rdEnd_q, calibDone_q, syncRst_q;

  logic [ADDR_SIZE-1:0] cmdAddr;
  idx_t                 cmdIdx, memIdx, rdWord;
  logic                 wdfEmpty, wdfFull, wdfRdy, beatIn, dataAvail;
  logic                 wdfPop, wdfBypass, wdfPush, memWe;
  logic [DATA_SIZE-1:0] memData;
  logic [BytesW-1:0]    memMask;
  logic                 latDone, burstDone, emit;
  logic [BurstLg-1:0]   rdBeat;

  assign cmdAddr   = ui.app_addr;
  assign cmdIdx    = MEM_WORDS_LG'(cmdAddr >> ByteLg);
  assign wdfEmpty  = (wdfCnt_q == '0);
  assign wdfFull   = (wdfCnt_q == (WdfLg+1)'(WDF_DEPTH));
  assign wdfRdy    = (state_q != CALIB) && !wdfFull;
  assign beatIn    = ui.app_wdf_wren && wdfRdy;
  assign dataAvail = !wdfEmpty || beatIn;
  // The FIFO head is older than any beat arriving this cycle, so it always wins.
  assign memData   = wdfEmpty ? ui.app_wdf_data : wdfData_q[wdfRd_q];
  assign memMask   = wdfEmpty ? ui.app_wdf_mask : wdfMask_q[wdfRd_q];
  assign wdfPush   = beatIn && !wdfBypass;
  assign latDone   = (latCnt_q == LatW'(RD_LATENCY - 1));
  assign burstDone = (beatCnt_q == (BurstLg+1)'(BURST_LEN));

  always_comb begin
    state_d   = state_q;
    calCnt_d  = calCnt_q;
    latCnt_d  = latCnt_q;
    beatCnt_d = beatCnt_q;
    rdIdx_d   = rdIdx_q;
    wrIdx_d   = wrIdx_q;
    memWe     = 1'b0;
    memIdx    = cmdIdx;
    wdfPop    = 1'b0;
    wdfBypass = 1'b0;
    case (state_q)
      CALIB: begin
        if (calCnt_q == CalW'(CALIB_CYCLES - 1)) state_d = IDLE;
        else calCnt_d = calCnt_q + 1'b1;
      end
      IDLE: begin
        if (ui.app_en) begin
          if (ui.app_cmd == CmdWrite) begin
            if (dataAvail) begin
              memWe     = 1'b1;
              memIdx    = cmdIdx;
              wdfPop    = !wdfEmpty;
              wdfBypass = wdfEmpty;
            end else begin
              wrIdx_d = cmdIdx;
              state_d = WDWAIT;
            end
          end else if (ui.app_cmd == CmdRead) begin
            rdIdx_d  = cmdIdx;
            latCnt_d = '0;
            state_d  = RDLAT;
          end
        end
      end
      WDWAIT: begin
        if (dataAvail) begin
          memWe     = 1'b1;
          memIdx    = wrIdx_q;
          wdfPop    = !wdfEmpty;
          wdfBypass = wdfEmpty;
          state_d   = IDLE;
        end
      end
      RDLAT: begin
        if (latDone) begin
          state_d   = RDBURST;
          beatCnt_d = (BurstLg+1)'(1);
        end else begin
          latCnt_d = latCnt_q + 1'b1;
        end
      end
      RDBURST: begin
        if (burstDone) state_d = IDLE;
        else beatCnt_d = beatCnt_q + 1'b1;
      end
      default: state_d = CALIB;
    endcase
  end

  // Beat 0 leaves on the last latency edge; later beats wrap inside the aligned burst block.
  assign emit   = ((state_q == RDLAT) && latDone) || ((state_q == RDBURST) && !burstDone);
  assign rdBeat = (state_q == RDBURST) ? beatCnt_q[BurstLg-1:0] : '0;
  assign rdWord = {rdIdx_q[MEM_WORDS_LG-1:BurstLg], rdIdx_q[BurstLg-1:0] + rdBeat};

  always_ff @(posedge ui_clk) begin
    syncRst_q <= sys_reset;
    if (sys_reset) begin
      state_q     <= CALIB;
      calCnt_q    <= '0;
      latCnt_q    <= '0;
      beatCnt_q   <= '0;
      rdIdx_q     <= '0;
      wrIdx_q     <= '0;
      rdData_q    <= '0;
      rdValid_q   <= 1'b0;
      rdEnd_q     <= 1'b0;
      calibDone_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      calCnt_q    <= calCnt_d;
      latCnt_q    <= latCnt_d;
      beatCnt_q   <= beatCnt_d;
      rdIdx_q     <= rdIdx_d;
      wrIdx_q     <= wrIdx_d;
      rdData_q    <= emit ? mem[rdWord] : '0;
      rdValid_q   <= emit;
      rdEnd_q     <= emit && (rdBeat == BurstLg'(BURST_LEN - 1));
      calibDone_q <= (state_d != CALIB);
    end
  end

  always_ff @(posedge ui_clk) begin
    if (sys_reset) begin
      wdfRd_q  <= '0;
      wdfWr_q  <= '0;
      wdfCnt_q <= '0;
    end else begin
      if (wdfPush) wdfWr_q <= wdfWr_q + 1'b1;
      if (wdfPop)  wdfRd_q <= wdfRd_q + 1'b1;
      case ({wdfPush, wdfPop})
        2'b10:   wdfCnt_q <= wdfCnt_q + 1'b1;
        2'b01:   wdfCnt_q <= wdfCnt_q - 1'b1;
        default: wdfCnt_q <= wdfCnt_q;
      endcase
    end
  end

  // Storage arrays carry no reset: committed data survives a reset.
  always_ff @(posedge ui_clk) begin
    if (wdfPush && !sys_reset) begin
      wdfData_q[wdfWr_q] <= ui.app_wdf_data;
      wdfMask_q[wdfWr_q] <= ui.app_wdf_mask;
    end
    if (memWe && !sys_reset) begin
      for (int b = 0; b < BytesW; b++) begin
        if (!memMask[b]) mem[memIdx][8*b +: 8] <= memData[8*b +: 8];
      end
    end
  end

  a_wdf_end: assert property (@(posedge ui_clk) disable iff (sys_reset)
                              ui.app_wdf_wren |-> ui.app_wdf_end);

  assign ui_clk_sync_rst        = syncRst_q;
  assign ui.app_rdy             = (state_q == IDLE);
  assign ui.app_wdf_rdy         = wdfRdy;
  assign ui.app_rd_data         = rdData_q;
  assign ui.app_rd_data_valid   = rdValid_q;
  assign ui.app_rd_data_end     = rdEnd_q;
  assign ui.init_calib_complete = calibDone_q;
endmodule

// File: tb/tb_xui_mem_model.sv
// Scoreboard bench for xui_mem_model: a word-array reference model predicts every read beat
// (data, end flag and arrival cycle); a negedge monitor pops and compares each beat.
module tb_xui_mem_model;
  localparam int AW = 31, DW = 64, BL = 8, LAT = 4, CAL = 16, WDF = 4;

  logic ui_clk = 1'b0;
  logic sys_reset = 1'b1;
  logic ui_clk_sync_rst;

  xui_mem_model_if #(.ADDR_SIZE(AW), .DATA_SIZE(DW)) ui ();

  xui_mem_model #(
    .ADDR_SIZE(AW), .DATA_SIZE(DW), .BURST_LEN(BL), .MEM_WORDS_LG(12),
    .CALIB_CYCLES(CAL), .RD_LATENCY(LAT), .WDF_DEPTH(WDF)
  ) dut (
    .ui_clk(ui_clk),
    .sys_reset(sys_reset),
    .ui_clk_sync_rst(ui_clk_sync_rst),
    .ui(ui)
  );

  always #5 ui_clk = ~ui_clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge ui_clk) cyc <= cyc + 1;

  typedef struct { logic [63:0] data; logic [63:0] care; logic last; int due; } beat_t;
  typedef struct { logic [63:0] data; logic [7:0] mask; } wbeat_t;
  beat_t  sbQ[$];
  wbeat_t wdfQ[$];
  beat_t  mon;
  logic [63:0] refMem [4096];
  logic [7:0]  refKnown [4096];
  bit waitPending = 0;
  int waitIdx = 0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard monitor: sampled on the falling edge, away from the active edge.
  always @(negedge ui_clk) begin
    if (ui.app_rd_data_valid === 1'b1) begin
      if (sbQ.size() == 0) begin
        checkOutput("unexpected_beat", 64'd1, 64'd0);
      end else begin
        mon = sbQ.pop_front();
        checkOutput("rd_data", ui.app_rd_data & mon.care, mon.data & mon.care);
        checkOutput("rd_end", {63'd0, ui.app_rd_data_end}, {63'd0, mon.last});
        checkOutput("rd_cycle", 64'(cyc), 64'(mon.due));
      end
    end else begin
      checkOutput("rd_data_idle_zero", ui.app_rd_data, 64'd0);
      if (sbQ.size() > 0 && sbQ[0].due < cyc) begin
        checkOutput("missing_beat", 64'(cyc), 64'(sbQ[0].due));
        void'(sbQ.pop_front());
      end
    end
  end

  function automatic int wordOf(input logic [30:0] a);
    return int'((a >> 3) & 31'd4095);
  endfunction

  function automatic logic [63:0] careOf(input logic [7:0] k);
    logic [63:0] c = '0;
    for (int b = 0; b < 8; b++) c[8*b +: 8] = {8{k[b]}};
    return c;
  endfunction

  function automatic void modelWrite(input int idx, input logic [63:0] d, input logic [7:0] m);
    for (int b = 0; b < 8; b++) begin
      if (!m[b]) begin
        refMem[idx][8*b +: 8] = d[8*b +: 8];
        refKnown[idx][b] = 1'b1;
      end
    end
  endfunction

  task automatic tick();
    @(posedge ui_clk);
    #2;
  endtask

  task automatic applyStimulus(input bit en, input logic [2:0] cmd, input logic [30:0] addr,
                               input bit wren, input logic [63:0] data, input logic [7:0] mask);
    ui.app_en       = en;
    ui.app_cmd      = cmd;
    ui.app_addr     = addr;
    ui.app_wdf_wren = wren;
    ui.app_wdf_data = data;
    ui.app_wdf_mask = mask;
    ui.app_wdf_end  = wren;
    tick();
    ui.app_en       = 1'b0;
    ui.app_wdf_wren = 1'b0;
    ui.app_wdf_end  = 1'b0;
  endtask

  task automatic waitRdy(input string name);
    int n = 0;
    while (ui.app_rdy !== 1'b1 && n < 300) begin
      tick();
      n++;
    end
    if (n >= 300) checkOutput({name, "_rdy_timeout"}, 64'd0, 64'd1);
  endtask

  task automatic waitIdle();
    int n = 0;
    waitRdy("idle");
    while (sbQ.size() > 0 && n < 300) begin
      tick();
      n++;
    end
    if (n >= 300) checkOutput("drain_timeout", 64'(sbQ.size()), 64'd0);
  endtask

  task automatic writeCmd(input logic [30:0] addr, input bit withData,
                          input logic [63:0] data, input logic [7:0] mask);
    wbeat_t wb;
    waitRdy("write");
    applyStimulus(1'b1, 3'b000, addr, withData, data, mask);
    if (wdfQ.size() > 0) begin
      wb = wdfQ.pop_front();
      modelWrite(wordOf(addr), wb.data, wb.mask);
      if (withData) wdfQ.push_back('{data, mask});
    end else if (withData) begin
      modelWrite(wordOf(addr), data, mask);
    end else begin
      waitPending = 1'b1;
      waitIdx = wordOf(addr);
    end
  endtask

  task automatic pushBeat(input logic [63:0] data, input logic [7:0] mask);
    bit expRdy = (wdfQ.size() < WDF);
    checkOutput("wdf_rdy", {63'd0, ui.app_wdf_rdy}, {63'd0, expRdy});
    if (expRdy) begin
      applyStimulus(1'b0, 3'b000, 31'd0, 1'b1, data, mask);
      if (waitPending) begin
        modelWrite(waitIdx, data, mask);
        waitPending = 1'b0;
      end else begin
        wdfQ.push_back('{data, mask});
      end
    end
  endtask

  task automatic readCmd(input logic [30:0] addr, output int t);
    int w, base, wk;
    waitRdy("read");
    t = cyc + 1;
    applyStimulus(1'b1, 3'b001, addr, 1'b0, 64'd0, 8'd0);
    w = wordOf(addr);
    base = w - (w % BL);
    for (int k = 0; k < BL; k++) begin
      wk = base + ((w + k) % BL);
      sbQ.push_back('{refMem[wk], careOf(refKnown[wk]), (k == BL - 1), t + LAT + k});
    end
  endtask

  task automatic checkCalibration(input string name);
    for (int n = 1; n <= CAL; n++) begin
      tick();
      checkOutput({name, "_calib_complete"}, {63'd0, ui.init_calib_complete}, {63'd0, (n >= CAL)});
      checkOutput({name, "_app_rdy"}, {63'd0, ui.app_rdy}, {63'd0, (n >= CAL)});
      if (n == 1) checkOutput({name, "_sync_rst_low"}, {63'd0, ui_clk_sync_rst}, 64'd0);
    end
  endtask

  initial begin
    int t, t2, r;
    logic [30:0] a;
    logic [63:0] d;
    ui.app_en = 0; ui.app_cmd = 0; ui.app_addr = 0; ui.app_wdf_wren = 0;
    ui.app_wdf_data = 0; ui.app_wdf_mask = 0; ui.app_wdf_end = 0;
    for (int i = 0; i < 4096; i++) refKnown[i] = 8'h00;

    // Reset and calibration
    repeat (3) tick();
    checkOutput("reset_sync_rst", {63'd0, ui_clk_sync_rst}, 64'd1);
    checkOutput("reset_calib", {63'd0, ui.init_calib_complete}, 64'd0);
    checkOutput("reset_app_rdy", {63'd0, ui.app_rdy}, 64'd0);
    checkOutput("reset_wdf_rdy", {63'd0, ui.app_wdf_rdy}, 64'd0);
    checkOutput("reset_rd_valid", {63'd0, ui.app_rd_data_valid}, 64'd0);
    sys_reset = 1'b0;
    checkCalibration("boot");

    // Single full-word write, then read back with latency/burst checks
    writeCmd(31'h80, 1'b1, 64'h1122334455667788, 8'h00);
    readCmd(31'h80, t);
    waitIdle();

    // Back-to-back writes of words 0..7, critical-word-first read from 0x28
    for (int i = 0; i < 8; i++) begin
      writeCmd(31'(i * 8), 1'b1, 64'(i), 8'h00);
      checkOutput("rdy_after_write", {63'd0, ui.app_rdy}, 64'd1);
    end
    readCmd(31'h28, t);
    waitIdle();

    // Byte mask: upper half kept
    writeCmd(31'h40, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00);
    writeCmd(31'h40, 1'b1, 64'h0, 8'hF0);
    readCmd(31'h40, t);
    waitIdle();

    // Write command without data waits, data arrives three cycles later
    writeCmd(31'h100, 1'b0, 64'd0, 8'd0);
    for (int i = 0; i < 2; i++) begin
      checkOutput("rdy_wdwait", {63'd0, ui.app_rdy}, 64'd0);
      tick();
    end
    checkOutput("rdy_wdwait", {63'd0, ui.app_rdy}, 64'd0);
    pushBeat(64'hAB, 8'h00);
    checkOutput("rdy_after_wdwait", {63'd0, ui.app_rdy}, 64'd1);
    readCmd(31'h100, t);
    waitIdle();

    // Unsupported command is accepted and dropped
    applyStimulus(1'b1, 3'b010, 31'h80, 1'b0, 64'd0, 8'd0);
    checkOutput("rdy_after_other_cmd", {63'd0, ui.app_rdy}, 64'd1);

    // Read-to-read spacing
    readCmd(31'h28, t);
    waitRdy("spacing");
    t2 = cyc + 1;
    checkOutput("rd_spacing", 64'(t2 - t), 64'(LAT + BL + 1));
    readCmd(31'h80, t);
    waitIdle();

    // Fill the WDF during a burst; a fifth beat is refused; four writes drain it in order
    readCmd(31'h00, t);
    for (int j = 0; j < WDF; j++) pushBeat({$urandom, $urandom}, 8'h00);
    checkOutput("wdf_full", {63'd0, ui.app_wdf_rdy}, 64'd0);
    checkOutput("rdy_in_burst", {63'd0, ui.app_rdy}, 64'd0);
    applyStimulus(1'b0, 3'b000, 31'd0, 1'b1, 64'hDEAD_BEEF_DEAD_BEEF, 8'h00);
    waitIdle();
    for (int j = 0; j < WDF; j++) begin
      writeCmd(31'(32'h200 + j * 8), 1'b0, 64'd0, 8'd0);
      checkOutput("rdy_drain_write", {63'd0, ui.app_rdy}, 64'd1);
    end
    checkOutput("wdf_rdy_drained", {63'd0, ui.app_wdf_rdy}, 64'd1);
    readCmd(31'h200, t);
    waitIdle();

    // Randomized traffic, with upper address bits that must alias
    for (int it = 0; it < 60; it++) begin
      a = 31'(($urandom_range(0, 63) << 3) | ($urandom_range(0, 3) << 15));
      d = {$urandom, $urandom};
      case ($urandom_range(0, 3))
        0: writeCmd(a, (wdfQ.size() == 0), d, 8'($urandom_range(0, 255)));
        1: if (wdfQ.size() < WDF) pushBeat(d, 8'($urandom_range(0, 255)));
        2: begin readCmd(a, t); waitIdle(); end
        default: if (wdfQ.size() == 0) begin
          writeCmd(a, 1'b0, 64'd0, 8'd0);
          r = $urandom_range(0, 2);
          repeat (r) tick();
          checkOutput("rdy_rand_wdwait", {63'd0, ui.app_rdy}, 64'd0);
          pushBeat(d, 8'($urandom_range(0, 255)));
        end
      endcase
    end
    while (wdfQ.size() > 0) writeCmd(31'($urandom_range(0, 63) << 3), 1'b0, 64'd0, 8'd0);
    for (int blk = 0; blk < 8; blk++) begin
      readCmd(31'(blk * 64 + 8 * $urandom_range(0, 7)), t);
      waitIdle();
    end

    // Reset in the middle of a burst
    readCmd(31'h00, t);
    r = 0;
    while (ui.app_rd_data_valid !== 1'b1 && r < 50) begin
      tick();
      r++;
    end
    if (r >= 50) checkOutput("burst_start_timeout", 64'd0, 64'd1);
    tick();
    tick();
    sys_reset = 1'b1;
    tick();
    sbQ.delete();
    wdfQ.delete();
    waitPending = 1'b0;
    checkOutput("midreset_valid", {63'd0, ui.app_rd_data_valid}, 64'd0);
    checkOutput("midreset_data", ui.app_rd_data, 64'd0);
    checkOutput("midreset_end", {63'd0, ui.app_rd_data_end}, 64'd0);
    checkOutput("midreset_calib", {63'd0, ui.init_calib_complete}, 64'd0);
    checkOutput("midreset_app_rdy", {63'd0, ui.app_rdy}, 64'd0);
    checkOutput("midreset_sync_rst", {63'd0, ui_clk_sync_rst}, 64'd1);
    sys_reset = 1'b0;
    checkCalibration("recal");
    readCmd(31'h200, t);
    waitIdle();
    readCmd(31'h28, t);
    waitIdle();

    repeat (4) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "[TB] watchdog expired");
  end
endmodule
